osd_dem_uart_tx_sched: RTL

// - Schedules NCH UART TX char streams onto one DII debug_out port as event packets.
// - Round-robin channel grant; batches up to MAX_CHARS chars of one channel per packet.
// - Closes a packet on the size limit or on an idle timeout.
// - Sits between the UART-side char sources and the module's ring_router_mux local input.

---
 rtl/osd_dem_uart_tx_sched_if.sv | 21 ++
 rtl/osd_dem_uart_tx_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/osd_dem_uart_tx_sched_if.sv
// DII flit port of the UART TX scheduler: valid/last/data from the source, ready from the sink.
interface osd_dem_uart_tx_sched_if;
  logic        valid;
  logic        last;
  logic [15:0] data;
  logic        ready;

  modport master (
    output valid,
    output last,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  data,
    output ready
  );
endinterface

// File: rtl/osd_dem_uart_tx_sched.sv
// UART TX char scheduler: round-robin grant over NCH char channels, each grant producing one
// DII event packet (DEST, SRC header, up to MAX_CHARS payload flits) closed on size or timeout.
// Optional macro OSD_DEM_UART_TX_SCHED_STATS_EN builds the packet/char statistics counters.
module osd_dem_uart_tx_sched #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned MAX_CHARS = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [15:0] DEST      = 16'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                id,
  input  logic                      stall,
  input  logic [8*NCH-1:0]          in_char,
  input  logic [NCH-1:0]            in_valid,
  output logic [NCH-1:0]            in_ready,
  osd_dem_uart_tx_sched_if.master   debug_out,
  output logic                      busy,
  output logic [15:0]               stat_pkts,
  output logic [15:0]               stat_chars
);

  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW = $clog2(MAX_CHARS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StHdrDest, StHdrSrc, StPayload} state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  rr_q, rr_d;
  logic [GW-1:0]  gnt_q, gnt_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_v_q, hold_v_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;

  logic [7:0]     chars [NCH];
  logic [GW-1:0]  sel;
  logic           any_valid;
  logic           close;
  logic           out_valid;
  logic           out_last;
  logic [15:0]    out_data;

  // Unpack the flat char bus into per-channel bytes.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      chars[k] = in_char[8*k +: 8];
    end
  end

  // Round-robin pick: first valid channel strictly after rr_q, wrapping.
  always_comb begin
    logic [GW-1:0] idx;
    sel       = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = GW'((32'(rr_q) + i) % NCH);
      if (!any_valid && in_valid[idx]) begin
        any_valid = 1'b1;
        sel       = idx;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_q     <= GW'(NCH - 1);
      gnt_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
    end
  end

  // Next-state, grant and flit generation.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    in_ready  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 16'h0;
    close     = (cnt_q == CW'(MAX_CHARS)) || (tmr_q == TW'(TIMEOUT));

    unique case (state_q)
      StIdle: begin
        // rst gating keeps in_ready low while reset is held.
        if (!rst && !stall && any_valid) begin
          in_ready[sel] = 1'b1;
          hold_d        = chars[sel];
          hold_v_d      = 1'b1;
          cnt_d         = CW'(1);
          tmr_d         = '0;
          rr_d          = sel;
          gnt_d         = sel;
          state_d       = StHdrDest;
        end
      end
      StHdrDest: begin
        out_valid = 1'b1;
        out_data  = DEST;
        if (debug_out.ready) state_d = StHdrSrc;
      end
      StHdrSrc: begin
        out_valid = 1'b1;
        out_data  = {2'b01, 4'h1, id};
        if (debug_out.ready) state_d = StPayload;
      end
      StPayload: begin
        out_data = {8'(gnt_q), hold_q};
        if (close) begin
          out_valid = hold_v_q;
          out_last  = 1'b1;
          if (debug_out.ready) begin
            hold_v_d = 1'b0;
            state_d  = StIdle;
          end
        end else if (in_valid[gnt_q]) begin
          // A non-final flit is offered only once the next char is waiting: that char
          // is what proves the held one is not last, and both move on the same edge.
          out_valid       = hold_v_q;
          in_ready[gnt_q] = debug_out.ready;
          if (debug_out.ready) begin
            hold_d = chars[gnt_q];
            cnt_d  = cnt_q + CW'(1);
            tmr_d  = '0;
          end
        end else begin
          // close is low here, so tmr_q < TIMEOUT and this saturates at TIMEOUT.
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign debug_out.valid = out_valid;
  assign debug_out.last  = out_last;
  assign debug_out.data  = out_data;
  assign busy            = (state_q != StIdle);

`ifdef OSD_DEM_UART_TX_SCHED_STATS_EN
  logic [15:0] pkts_q;
  logic [15:0] chars_q;

  // Wrapping counters of last-flit and payload-flit transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkts_q  <= 16'h0;
      chars_q <= 16'h0;
    end else begin
      if (out_valid && debug_out.ready && out_last) pkts_q <= pkts_q + 16'd1;
      if (out_valid && debug_out.ready && (state_q == StPayload)) chars_q <= chars_q + 16'd1;
    end
  end

  assign stat_pkts  = pkts_q;
  assign stat_chars = chars_q;
`else
  assign stat_pkts  = 16'h0;
  assign stat_chars = 16'h0;
`endif

endmodule
